// File: rtl/pb_dipsw_debounce_pkg.sv
// Shared types and defaults for the push-button / DIP-switch input conditioner.
package pb_debounce_pkg;

  // Per-channel filter state: IDLE holds the accepted level, PENDING times a candidate level.
  typedef enum logic {
    DB_IDLE    = 1'b0,
    DB_PENDING = 1'b1
  } db_state_t;

  // Default synchroniser depth (flops between the raw pin and the filter).
  localparam int DB_SYNC_STAGES_DEF = 2;

  // Default hold time in clocks: 10 ms at 100 MHz.
  localparam int DB_CYCLES_DEF = 1000000;

  // Pulse that marks a channel leaving its idle level, given its rise/fall pulses.
  function automatic logic db_leave_idle(input logic rise, input logic fall, input logic idle_lvl);
    return idle_lvl ? fall : rise;
  endfunction

  // Pulse that marks a channel returning to its idle level, given its rise/fall pulses.
  function automatic logic db_return_idle(input logic rise, input logic fall, input logic idle_lvl);
    return idle_lvl ? rise : fall;
  endfunction

endpackage

// File: rtl/pb_dipsw_debounce_chan.sv
// One debounce channel: N-flop synchroniser, then a 2-state hold-time filter.
// The accepted level and its rise/fall pulses are all flop outputs.
module debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DB_SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DB_CYCLES_DEF,
  parameter logic IDLE_LVL        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // Counter only ever reaches DEBOUNCE_CYCLES-1, where the accept transition clears it.
  localparam int            CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_s;

  db_state_t              state_q;
  db_state_t              state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;

  // Shift the raw pin into the synchroniser chain; the last stage is the filter input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    sync_s = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser flops; they come out of reset at the idle level so no spurious edge is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Filter next-state: a new level must persist DEBOUNCE_CYCLES clocks, any return restarts it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync_s != stable_q) begin
          state_d = DB_PENDING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      DB_PENDING: begin
        if (sync_s == stable_q) begin
          // Glitch ended before the hold time; drop it without touching the output.
          state_d = DB_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DB_IDLE;
          cnt_d    = CNT_ZERO;
          stable_d = sync_s;
          rise_d   = sync_s;
          fall_d   = ~sync_s;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Filter state, hold counter, accepted level and edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= DB_IDLE;
      cnt_q    <= CNT_ZERO;
      stable_q <= IDLE_LVL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign dout = stable_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pb_dipsw_debounce.sv
// Input conditioner for board push-buttons and DIP switches: one independent
// debounce channel per pin, plus press/release/change pulses for fabric logic.
module pb_dipsw_debounce
  import pb_debounce_pkg::*;
#(
  parameter int   N_PB            = 2,
  parameter int   N_SW            = 2,
  parameter int   SYNC_STAGES     = DB_SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DB_CYCLES_DEF,
  parameter logic PB_IDLE         = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_PB-1:0] pb_in,
  input  logic [N_SW-1:0] dipsw_in,
  output logic [N_PB-1:0] pb_out,
  output logic [N_PB-1:0] pb_press,
  output logic [N_PB-1:0] pb_release,
  output logic [N_SW-1:0] dipsw_out,
  output logic [N_SW-1:0] dipsw_change
);

  logic [N_PB-1:0] pb_rise_s;
  logic [N_PB-1:0] pb_fall_s;
  logic [N_SW-1:0] sw_rise_s;
  logic [N_SW-1:0] sw_fall_s;

  // Push-button channels idle at PB_IDLE; press/release follow the idle polarity.
  for (genvar i = 0; i < N_PB; i++) begin : g_pb
    debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LVL        (PB_IDLE)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (pb_in[i]),
      .dout  (pb_out[i]),
      .rise  (pb_rise_s[i]),
      .fall  (pb_fall_s[i])
    );

    assign pb_press[i]   = db_leave_idle(pb_rise_s[i], pb_fall_s[i], PB_IDLE);
    assign pb_release[i] = db_return_idle(pb_rise_s[i], pb_fall_s[i], PB_IDLE);
  end

  // DIP-switch channels idle low; any accepted transition is reported as a change.
  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LVL        (1'b0)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .din   (dipsw_in[j]),
      .dout  (dipsw_out[j]),
      .rise  (sw_rise_s[j]),
      .fall  (sw_fall_s[j])
    );

    assign dipsw_change[j] = sw_rise_s[j] | sw_fall_s[j];
  end

endmodule

// File: tb/tb_pb_dipsw_debounce.sv
// Directed bench for pb_dipsw_debounce with a short hold time (16 clocks).
module tb_pb_dipsw_debounce;

  localparam int LAT = 2 + 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] pb_in;
  logic [1:0] dipsw_in;
  logic [1:0] pb_out;
  logic [1:0] pb_press;
  logic [1:0] pb_release;
  logic [1:0] dipsw_out;
  logic [1:0] dipsw_change;

  int total = 0;
  int bad   = 0;

  logic [1:0] cur_pb;
  logic [1:0] cur_sw;

  typedef struct {
    logic [1:0] pb;
    logic [1:0] sw;
    logic [1:0] exp_pb;
    logic [1:0] exp_sw;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
    logic [1:0] exp_chg;
  } vec_t;

  vec_t vecs [6];

  pb_dipsw_debounce #(
    .N_PB            (2),
    .N_SW            (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .PB_IDLE         (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pb_in        (pb_in),
    .dipsw_in     (dipsw_in),
    .pb_out       (pb_out),
    .pb_press     (pb_press),
    .pb_release   (pb_release),
    .dipsw_out    (dipsw_out),
    .dipsw_change (dipsw_change)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {pb_out, dipsw_out, pb_press, pb_release, dipsw_change};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pb/sw/press/rel/chg=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_steady(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      edge1();
      chk(name, outs(), {cur_pb, cur_sw, 6'b000000});
    end
  endtask

  // Output must hold for LAT-1 edges, change with pulses on edge LAT, pulses gone on LAT+1.
  task automatic expect_latency(input vec_t v, input string name);
    for (int k = 1; k < LAT; k++) begin
      edge1();
      chk({name, "_hold"}, outs(), {cur_pb, cur_sw, 6'b000000});
    end
    edge1();
    chk({name, "_edge"}, outs(), {v.exp_pb, v.exp_sw, v.exp_press, v.exp_rel, v.exp_chg});
    cur_pb = v.exp_pb;
    cur_sw = v.exp_sw;
    edge1();
    chk({name, "_after"}, outs(), {cur_pb, cur_sw, 6'b000000});
  endtask

  initial begin
    //             pb     sw     exp_pb exp_sw press  rel    chg
    vecs[0] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    vecs[1] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00};
    vecs[2] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    vecs[3] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10};
    vecs[4] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
    vecs[5] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10};

    // Reset with buttons held: outputs sit at idle regardless of pins.
    reset    = 1'b1;
    pb_in    = 2'b00;
    dipsw_in = 2'b00;
    #1;
    chk("reset_async", outs(), {2'b11, 2'b00, 6'b000000});
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("reset_held", outs(), {2'b11, 2'b00, 6'b000000});
    end
    pb_in  = 2'b11;
    edge1();
    reset  = 1'b0;
    cur_pb = 2'b11;
    cur_sw = 2'b00;
    expect_steady(5, "post_reset");

    // Clean transitions, including a press and simultaneous switch changes.
    for (int i = 0; i < 6; i++) begin
      pb_in    = vecs[i].pb;
      dipsw_in = vecs[i].sw;
      expect_latency(vecs[i], $sformatf("vec%0d", i));
    end

    // Bouncing button 1: twelve 5-cycle toggles, then held pressed.
    for (int i = 0; i < 12; i++) begin
      pb_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      expect_steady(5, "bounce_reject");
    end
    pb_in[1] = 1'b0;
    expect_latency('{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00}, "bounce_accept");

    // Switch 0 glitch one cycle short of the hold time: never accepted.
    dipsw_in[0] = 1'b1;
    expect_steady(15, "glitch_high");
    dipsw_in[0] = 1'b0;
    expect_steady(25, "glitch_after");

    // Release button 1 again.
    pb_in = 2'b11;
    expect_latency('{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00}, "release1");

    // Reset while button 0 is pending, pin stays pressed across reset.
    pb_in[0] = 1'b0;
    expect_steady(10, "pend_before_rst");
    reset = 1'b1;
    #1;
    chk("mid_rst_async", outs(), {2'b11, 2'b00, 6'b000000});
    edge1();
    chk("mid_rst_held", outs(), {2'b11, 2'b00, 6'b000000});
    reset = 1'b0;
    expect_latency('{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00}, "after_rst");
    expect_steady(5, "after_rst_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
